// File: rtl/present_pkg.sv
// Shared constants and enumerations for the PRESENT job scheduler slice.
package present_pkg;

    localparam int KEY_W      = 80;
    localparam int DATA_W     = 64;
    localparam int NUM_ROUNDS = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } sched_state_t;

    typedef enum logic {
        ENC = 1'b0,
        DEC = 1'b1
    } op_mode_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. A lone requester always wins; on contention
// the pointer picks the winner. Purely combinational.
module rr_arbiter2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Grant selection: one-hot grant plus its index for the data muxes.
    always_comb begin
        grant     = 2'b00;
        grant_idx = 1'b0;
        case (valid)
            2'b01: begin
                grant     = 2'b01;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant     = 2'b10;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant     = ptr ? 2'b10 : 2'b01;
                grant_idx = ptr;
            end
            default: begin
                grant     = 2'b00;
                grant_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/present_job_scheduler.sv
// Shares one iterative PRESENT round core between two requesters: arbitrates,
// latches the job, drives the core Enable/Done handshake, guards it with a
// watchdog and returns a tagged result on a valid/ready channel.
module present_job_scheduler
    import present_pkg::*;
#(
    parameter int KEY_W   = present_pkg::KEY_W,
    parameter int DATA_W  = present_pkg::DATA_W,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 16
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_mode,
    input  logic [2*KEY_W-1:0]  req_key,
    input  logic [2*DATA_W-1:0] req_data,
    output logic                core_enable,
    output logic                core_mode,
    output logic [KEY_W-1:0]    core_key,
    output logic [DATA_W-1:0]   core_text,
    input  logic                core_done,
    input  logic [DATA_W-1:0]   core_result,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic                resp_id,
    output logic [DATA_W-1:0]   resp_data,
    output logic                resp_err,
    output logic                busy,
    output logic [CNT_W-1:0]    jobs_done
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t        state_reg, state_next;
    op_mode_t            mode_reg, mode_next;
    logic [KEY_W-1:0]    key_reg, key_next;
    logic [DATA_W-1:0]   text_reg, text_next;
    logic                id_reg, id_next;
    logic [DATA_W-1:0]   resp_data_reg, resp_data_next;
    logic                resp_err_reg, resp_err_next;
    logic [WD_W-1:0]     wd_reg, wd_next;
    logic                rr_reg, rr_next;
    logic [CNT_W-1:0]    jobs_reg, jobs_next;

    logic [1:0]          grant;
    logic                grant_idx;
    logic [KEY_W-1:0]    key_slice  [2];
    logic [DATA_W-1:0]   data_slice [2];

    // Unpack the flat per-requester buses.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign key_slice[gi]  = req_key[gi*KEY_W +: KEY_W];
            assign data_slice[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter2 u_arb (
        .valid     (req_valid),
        .ptr       (rr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Requests are only accepted while idle; nothing is queued.
    assign req_ready   = (state_reg == IDLE) ? grant : 2'b00;
    assign core_enable = (state_reg == RUN);
    assign resp_valid  = (state_reg == RESP);
    assign busy        = (state_reg != IDLE);
    assign core_mode   = mode_reg;
    assign core_key    = key_reg;
    assign core_text   = text_reg;
    assign resp_id     = id_reg;
    assign resp_data   = resp_data_reg;
    assign resp_err    = resp_err_reg;
    assign jobs_done   = jobs_reg;

    // State, job and statistics registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg     <= IDLE;
            mode_reg      <= ENC;
            key_reg       <= '0;
            text_reg      <= '0;
            id_reg        <= 1'b0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
            wd_reg        <= '0;
            rr_reg        <= 1'b0;
            jobs_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            key_reg       <= key_next;
            text_reg      <= text_next;
            id_reg        <= id_next;
            resp_data_reg <= resp_data_next;
            resp_err_reg  <= resp_err_next;
            wd_reg        <= wd_next;
            rr_reg        <= rr_next;
            jobs_reg      <= jobs_next;
        end
    end

    // Next-state logic: accept, load, iterate under watchdog, respond.
    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        key_next       = key_reg;
        text_next      = text_reg;
        id_next        = id_reg;
        resp_data_next = resp_data_reg;
        resp_err_next  = resp_err_reg;
        wd_next        = wd_reg;
        rr_next        = rr_reg;
        jobs_next      = jobs_reg;
        case (state_reg)
            IDLE: begin
                if (|req_ready) begin
                    mode_next  = op_mode_t'(req_mode[grant_idx]);
                    key_next   = key_slice[grant_idx];
                    text_next  = data_slice[grant_idx];
                    id_next    = grant_idx;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                wd_next    = '0;
                state_next = RUN;
            end
            RUN: begin
                // Done takes priority over a coincident watchdog expiry.
                if (core_done) begin
                    resp_data_next = core_result;
                    resp_err_next  = 1'b0;
                    state_next     = RESP;
                end else if (wd_reg == WD_W'(TIMEOUT - 1)) begin
                    resp_data_next = '0;
                    resp_err_next  = 1'b1;
                    state_next     = RESP;
                end else begin
                    wd_next = wd_reg + WD_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    rr_next    = ~id_reg;
                    state_next = IDLE;
                    if (!resp_err_reg && (jobs_reg != {CNT_W{1'b1}})) begin
                        jobs_next = jobs_reg + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/present_job_scheduler.md
Name: present_job_scheduler

Overview:
Front-end controller that shares one iterative PRESENT round core (encrypt/decrypt selectable) between two requesters. It arbitrates round-robin, latches the winning job, and sequences the core's Enable/Done protocol: hold Enable low to load, then high to iterate. It returns the result on a valid/ready response channel tagged with the requester ID. A watchdog aborts jobs whose core never reports Done.

Parameters:
KEY_W, 80, key width
DATA_W, 64, block width
TIMEOUT, 40, max RUN cycles before abort (must exceed core round count)
CNT_W, 16, width of completed-job statistics counter

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
req_valid  in  2  per-requester job valid
req_ready  out  2  per-requester accept (one-hot or zero)
req_mode  in  2  per-requester op: 0 encrypt, 1 decrypt
req_key  in  2*KEY_W  per-requester key, requester i at [i*KEY_W +: KEY_W]
req_data  in  2*DATA_W  per-requester plaintext/ciphertext
core_enable  out  1  core Enable; low = load/hold, high = iterate
core_mode  out  1  selects encrypt or decrypt core
core_key  out  KEY_W  latched key to core
core_text  out  DATA_W  latched input block to core
core_done  in  1  core Done level
core_result  in  DATA_W  core output block
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that issued the job
resp_data  out  DATA_W  result block
resp_err  out  1  1 = watchdog abort, resp_data = 0
busy  out  1  high in any state except IDLE
jobs_done  out  CNT_W  count of error-free completed responses, saturating

Behaviour:
- Reset values: state IDLE; all outputs 0; rr pointer = 0; job registers 0; jobs_done = 0. Reset mid-job drops the job silently, with no response.
- States: IDLE -> LOAD -> RUN -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one valid: grant that requester.
  - Both valid: grant the requester equal to the rr pointer.
  - req_ready[g] is asserted combinationally in the same cycle; transfer occurs when valid & ready.
  - Latch mode/key/data/id, then go to LOAD.
- LOAD:
  - core_enable = 0 for exactly 1 cycle so the core loads core_text; watchdog cleared.
  - Go to RUN.
- RUN:
  - core_enable = 1; watchdog increments each cycle.
  - First cycle core_done = 1: register core_result into resp_data, resp_err = 0, go to RESP.
  - Otherwise, if the watchdog reaches TIMEOUT-1: resp_data = 0, resp_err = 1, go to RESP.
  - If done and timeout coincide, done wins.
- RESP:
  - resp_valid = 1; core_enable = 0, which parks/resets the core.
  - resp_data, resp_id and resp_err are held stable until resp_ready.
  - On resp_valid & resp_ready: go to IDLE; rr pointer = ~resp_id; jobs_done += 1 if !resp_err, saturating at all-ones.
- req_ready is 0 in all states except IDLE; requests wait, with no queueing.
- core_key, core_text and core_mode are held constant from LOAD through RESP, since the core's key schedule is combinational.
- Latency: job accepted at cycle T; core_enable high from T+2; resp_valid rises the cycle after core_done is first sampled high. Back-to-back acceptance is possible the cycle after the response handshake.
- Fairness: a requester that is continuously valid waits at most one job from the other requester.

Decomposition:
- Shared package present_pkg: KEY_W, DATA_W, NUM_ROUNDS constants; enum sched_state_t {IDLE, LOAD, RUN, RESP}; enum op_mode_t {ENC, DEC}.
- One sub-module, rr_arbiter2: 2-way round-robin grant from the valid vector and pointer, purely combinational.
- The scheduler holds the FSM, job registers, watchdog and stats.

Test Plan:
- Reset, then idle: all outputs 0, busy = 0, req_ready = 00, pointer 0.
- Requester 0: encrypt, key 0, data 0, with the real core -> resp_data = 0x5579C1387B228445, resp_id = 0, resp_err = 0, jobs_done = 1.
- Requester 1: decrypt, key 0, data 0x5579C1387B228445 -> resp_data = 0x0, resp_id = 1.
- Both valid continuously, stub core with Done after 5 RUN cycles:
  - Grants alternate 0,1,0,1.
  - Each resp_valid occurs 7 cycles after its accept.
- Stub core never asserts Done:
  - After TIMEOUT RUN cycles, resp_err = 1 and resp_data = 0.
  - jobs_done unchanged.
- Response backpressure and mid-job reset:
  - Hold resp_ready = 0 for 10 cycles: resp_* stable, req_ready = 00.
  - Assert Reset during RUN: outputs immediately 0, no response emitted, next job processed normally.
